fns_enc_23_seq: RTL and testbench

- Sequential Fibonacci-numeral-system (FNS) encoder for the 23-wire crosstalk-avoidance link; the transmit-side counterpart of the combinational 23-bit FNS decoder.
- Converts a binary data word into a 23-bit FNS codeword with the greedy (MSB-first, compare-and-subtract) algorithm, resolving one codeword bit per clock.
- Uses valid/ready handshakes on both sides.
- Sits between the data source and the bus driver.

---
 rtl/fns_enc_23_seq.sv | 98 +++++++++
 tb/tb_fns_enc_23_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fns_enc_23_seq.sv
// Sequential FNS encoder for the 23-wire crosstalk-avoidance link.
// Greedy MSB-first compare-and-subtract, one codeword bit per clock.
// codeout is only loaded on entry to DONE, so a half-built word never
// appears on the port.
module fns_enc_23_seq #(
  parameter int CW_W   = 23,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   codeout,
  output logic              out_err
);

  // Remainder width covers the full weight sum (75024 at CW_W=23).
  localparam int LIM_W = (DATA_W > 17) ? DATA_W : 17;
  localparam int CNT_W = $clog2(CW_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // w_k = F(k+1): 1, 1, 2, 3, 5, ...
  function automatic logic [LIM_W-1:0] fibw(input int k);
    logic [LIM_W-1:0] a, b, t;
    a = LIM_W'(1);
    b = LIM_W'(1);
    for (int i = 1; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (k == 0) ? a : b;
  endfunction

  // Inputs at or above F(CW_W+1) cannot be written without adjacent 1s.
  localparam logic [LIM_W-1:0] LIMIT = fibw(CW_W);

  logic [LIM_W-1:0] wtab [CW_W];
  for (genvar g = 0; g < CW_W; g++) begin : g_wt
    assign wtab[g] = fibw(g);
  end

  logic [1:0]       state;
  logic [LIM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [CW_W-1:0]  sh;
  logic             take;

  assign take      = (rem >= wtab[cnt]);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control FSM plus shadow-codeword datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      cnt     <= '0;
      sh      <= '0;
      codeout <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem     <= LIM_W'(data_in);
            out_err <= (LIM_W'(data_in) >= LIMIT);
            sh      <= '0;
            cnt     <= CNT_W'(CW_W - 1);
            state   <= RUN;
          end
        end
        RUN: begin
          sh[cnt] <= take;
          if (take) rem <= rem - wtab[cnt];
          if (cnt == '0) begin
            // Bit 0 is decided this cycle, so splice it in directly.
            codeout <= {sh[CW_W-1:1], take};
            state   <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_enc_23_seq.sv
// Directed + small random bench for fns_enc_23_seq.
module tb_fns_enc_23_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] codeout;
  logic        out_err;

  int n_run = 0;
  int n_fail = 0;
  int w [23];

  fns_enc_23_seq #(.CW_W(23), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .codeout(codeout), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dec(input logic [22:0] cw);
    int s = 0;
    for (int k = 0; k < 23; k++) if (cw[k]) s += w[k];
    return s;
  endfunction

  // Hand a word to the encoder and wait for out_valid; handshake is left open.
  task automatic start(input logic [15:0] d, output int lat);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    lat--;
    if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_out(input int dly);
    repeat (dly) @(negedge clk);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic enc(input logic [15:0] d, input string tag,
                     input logic [22:0] exp_cw, input logic exp_err);
    int lat;
    start(d, lat);
    chk({tag, "_cw"}, 32'(codeout), 32'(exp_cw));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    finish_out(0);
  endtask

  initial begin
    int lat;
    logic [22:0] cw0;
    logic        e0;
    logic        bad;
    logic [15:0] d;
    w[0] = 1; w[1] = 1;
    for (int k = 2; k < 23; k++) w[k] = w[k-1] + w[k-2];

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_codeout", 32'(codeout), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Minimum values and latency.
    start(16'd0, lat);
    chk("lat0", 32'(lat), 32'd23);
    chk("enc0_cw", 32'(codeout), 32'h0);
    chk("enc0_err", 32'(out_err), 32'd0);
    finish_out(0);
    chk("idle_after", 32'(in_ready), 32'd1);
    enc(16'd1, "enc1", 23'h000002, 1'b0);

    start(16'd100, lat);
    chk("lat100", 32'(lat), 32'd23);
    chk("enc100_cw", 32'(codeout), 32'h000428);
    chk("enc100_err", 32'(out_err), 32'd0);
    finish_out(0);

    enc(16'd46367, "enc46367", 23'h555554, 1'b0);
    enc(16'd46368, "enc46368", 23'h600000, 1'b1);
    enc(16'd7, "enc7", 23'h000014, 1'b0);

    start(16'd65535, lat);
    chk("enc65535_err", 32'(out_err), 32'd1);
    chk("enc65535_cw", 32'(codeout), 32'h78A408);
    chk("enc65535_sum", 32'(dec(codeout)), 32'd65535);
    finish_out(0);

    // Backpressure: DONE holds with out_ready low, new input not taken.
    start(16'd100, lat);
    cw0 = codeout;
    e0 = out_err;
    @(negedge clk);
    in_valid = 1'b1;
    data_in = 16'd5;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || codeout !== cw0 || out_err !== e0 || in_ready) bad = 1'b1;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_cw", 32'(codeout), 32'h000428);
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN discards the word.
    @(negedge clk) begin in_valid = 1'b1; data_in = 16'd100; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cw", 32'(codeout), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1 if (out_valid) bad = 1'b1;
    end
    chk("mid_rst_no_out", 32'(bad), 32'd0);

    // Random legal words with random backpressure.
    for (int i = 0; i < 300; i++) begin
      d = 16'($urandom_range(0, 46367));
      if (i == 0) d = 16'd46367;
      start(d, lat);
      bad = ((codeout & (codeout >> 1)) != 0) || (dec(codeout) != int'(d)) ||
            out_err || (lat != 23);
      if (bad) $display("FAIL rnd d=%0d got cw=%0h err=%0b lat=%0d", d, codeout, out_err, lat);
      chk("rnd", 32'(bad), 32'd0);
      finish_out($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
